// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the pushbutton hex-entry block.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam int NUM_KEYS = 19;

    localparam logic [4:0] KEY_BACK  = 5'd16;
    localparam logic [4:0] KEY_CLEAR = 5'd17;
    localparam logic [4:0] KEY_ENTER = 5'd18;

    // Lowest-index pressed button wins when several are held together.
    function automatic logic [4:0] lowest_key(input logic [NUM_KEYS-1:0] v);
        logic [4:0] k;
        k = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                k = 5'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/hex_entry_pb_synchronizer.sv
// Two-flop synchroniser for a bus of independent asynchronous buttons.
module pb_synchronizer #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Each bit passes through two flops before anything downstream sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/hex_entry.sv
// Pushbuttons -> debounced key events -> live 8-digit hex buffer with ENTER commit.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] pb,
    output logic [31:0]         seq,
    output logic [7:0]          digit_en,
    output logic [3:0]          count,
    output logic [31:0]         value,
    output logic                entered,
    output logic                overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] pb_s;

    state_t        state_q, state_d;
    logic [4:0]    key_q, key_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   seq_q, seq_d;
    logic [3:0]    count_q, count_d;
    logic [31:0]   value_q, value_d;
    logic          entered_q, entered_d;
    logic          overflow_q, overflow_d;

    pb_synchronizer #(
        .WIDTH(NUM_KEYS)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (pb),
        .q  (pb_s)
    );

    // State, debounce counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            seq_q      <= '0;
            count_q    <= '0;
            value_q    <= '0;
            entered_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            count_q    <= count_d;
            value_q    <= value_d;
            entered_q  <= entered_d;
            overflow_q <= overflow_d;
        end
    end

    // Debounce FSM; the key action is applied on the edge that leaves DEBOUNCE.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        count_d    = count_q;
        value_d    = value_q;
        entered_d  = 1'b0;
        overflow_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pb_s) begin
                    key_d   = lowest_key(pb_s);
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (!pb_s[key_q]) begin
                    // Bounce or glitch: drop it without any effect.
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    case (key_q)
                        KEY_BACK: begin
                            if (count_q != 4'd0) begin
                                seq_d   = seq_q >> 4;
                                count_d = count_q - 4'd1;
                            end
                        end
                        KEY_CLEAR: begin
                            seq_d   = '0;
                            count_d = '0;
                        end
                        KEY_ENTER: begin
                            value_d   = seq_q;
                            entered_d = 1'b1;
                            seq_d     = '0;
                            count_d   = '0;
                        end
                        default: begin
                            if (count_q == 4'd8) begin
                                overflow_d = 1'b1;
                            end else begin
                                seq_d   = {seq_q[27:0], key_q[3:0]};
                                count_d = count_q + 4'd1;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                // Every button must be seen low for the full window before re-arming.
                if (|pb_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit gi is lit whenever more than gi digits are held.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit_en
            assign digit_en[gi] = (count_q > 4'(gi));
        end
    endgenerate

    assign seq      = seq_q;
    assign count    = count_q;
    assign value    = value_q;
    assign entered  = entered_q;
    assign overflow = overflow_q;

endmodule
